alu_op_selector: RTL

Upstream front-end for the 4-bit ALU board demo. Debounces the raw active-low push buttons, steps the ALU operation code 0..OP_COUNT-1 with wrap-around, and registers the switch operands on a load button. All outputs are registered in a single clock domain. They drive the ALU `control`, `a` and `b` inputs directly and replace the button-clocked logic that currently drives them.

---
 rtl/alu_demo_pkg.sv | 34 +++
 rtl/alu_op_selector_btn_debouncer.sv | 61 ++++++
 rtl/alu_op_selector.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_demo_pkg.sv
// Shared definitions for the 4-bit ALU board demo: operation-code width,
// the operation codes as decoded by the ALU mux, and the wrap-around stepper.
package alu_demo_pkg;

   localparam int unsigned OP_W             = 4;
   localparam int unsigned OP_COUNT_DEFAULT = 10;

   typedef enum logic [OP_W-1:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_AND    = 4'd2,
      OP_OR     = 4'd3,
      OP_XOR    = 4'd4,
      OP_LSR    = 4'd5,
      OP_LSL    = 4'd6,
      OP_MOD    = 4'd7,
      OP_PASS_A = 4'd8,
      OP_DIV    = 4'd9
   } alu_op_e;

   // One step up or down through 0..last with wrap-around at both ends.
   function automatic logic [OP_W-1:0] op_step(input logic [OP_W-1:0] cur,
                                                input logic            up,
                                                input logic [OP_W-1:0] last);
      logic [OP_W-1:0] nxt;
      if (up) begin
         nxt = (cur == last) ? '0 : cur + 1'b1;
      end else begin
         nxt = (cur == '0) ? last : cur - 1'b1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/alu_op_selector_btn_debouncer.sv
// Button front-end: 2-FF synchronizer, counter-based debouncer and a
// registered one-cycle press pulse on the debounced 1->0 edge.
// With ALU_OP_SEL_AUTOREPEAT_EN defined, the debounced level is exported as
// 'held' so the top can run the auto-repeat timer.
module btn_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_n,
`ifdef ALU_OP_SEL_AUTOREPEAT_EN
   output logic held,
`endif
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic [1:0]       flush_q;
   logic             stable;
   logic             stable_q;
   logic             armed;
   logic [CNT_W-1:0] cnt;

   // A button held through reset must be released before it can count: 'armed'
   // only sets once a released level has come through the flushed synchronizer.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '1;
         flush_q  <= '0;
         stable   <= 1'b1;
         stable_q <= 1'b1;
         armed    <= 1'b0;
         cnt      <= '0;
         press    <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], raw_n};
         flush_q <= {flush_q[0], 1'b1};
         if (flush_q[1] && sync_q[1]) begin
            armed <= 1'b1;
         end
         if (sync_q[1] == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= sync_q[1];
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         stable_q <= stable;
         press    <= armed & stable_q & ~stable;
      end
   end

`ifdef ALU_OP_SEL_AUTOREPEAT_EN
   assign held = armed & ~stable;
`endif

endmodule

// File: rtl/alu_op_selector.sv
// Board front-end for the ALU demo: debounced next/prev buttons step the
// operation code with wrap-around, the load button captures the switch
// operands. All outputs registered in the clk domain.
// Optional feature macro: ALU_OP_SEL_AUTOREPEAT_EN (auto-repeat on held next/prev).
module alu_op_selector
   import alu_demo_pkg::*;
#(
   parameter int unsigned N               = 4,
   parameter int unsigned OP_COUNT        = OP_COUNT_DEFAULT,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_CYCLES   = 25000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            btn_next_n,
   input  logic            btn_prev_n,
   input  logic            btn_load_n,
   input  logic [N-1:0]    sw_a,
   input  logic [N-1:0]    sw_b,
   output logic [OP_W-1:0] control,
   output logic [N-1:0]    a,
   output logic [N-1:0]    b,
   output logic            op_changed,
   output logic            loaded
);

   localparam logic [OP_W-1:0] LAST_OP = OP_W'(OP_COUNT - 1);

   if (OP_COUNT < 2 || OP_COUNT > 16 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
      $error("alu_op_selector: illegal parameter value");
   end

   logic press_next;
   logic press_prev;
   logic press_load;
   logic step_up;
   logic step_dn;

   logic [N-1:0] sw_a_s0, sw_a_s1;
   logic [N-1:0] sw_b_s0, sw_b_s1;

`ifdef ALU_OP_SEL_AUTOREPEAT_EN
   localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES);

   logic             held_next;
   logic             held_prev;
   logic             load_held;
   logic             rep_q;
   logic [REP_W-1:0] rep_cnt;

   btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
      .clk(clk), .rst(rst), .raw_n(btn_next_n), .held(held_next), .press(press_next));
   btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
      .clk(clk), .rst(rst), .raw_n(btn_prev_n), .held(held_prev), .press(press_prev));
   btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
      .clk(clk), .rst(rst), .raw_n(btn_load_n), .held(load_held), .press(press_load));

   // Repeat timer runs only while exactly one of next/prev is held. It starts
   // from 0 when the level goes down and reloads 1 after each repeat, so the
   // first repeat lands REPEAT_CYCLES after the press pulse and later ones
   // are REPEAT_CYCLES apart.
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt <= '0;
         rep_q   <= 1'b0;
      end else if (!(held_next ^ held_prev)) begin
         rep_cnt <= '0;
         rep_q   <= 1'b0;
      end else if (rep_cnt == REP_LAST) begin
         rep_cnt <= REP_W'(1);
         rep_q   <= 1'b1;
      end else begin
         rep_cnt <= rep_cnt + 1'b1;
         rep_q   <= 1'b0;
      end
   end

   // Step requests: fresh presses plus repeats for whichever button is held.
   always_comb begin
      step_up = press_next | (rep_q & held_next);
      step_dn = press_prev | (rep_q & held_prev);
   end
`else
   btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
      .clk(clk), .rst(rst), .raw_n(btn_next_n), .press(press_next));
   btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
      .clk(clk), .rst(rst), .raw_n(btn_prev_n), .press(press_prev));
   btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
      .clk(clk), .rst(rst), .raw_n(btn_load_n), .press(press_load));

   // Step requests: exactly one per debounced press.
   always_comb begin
      step_up = press_next;
      step_dn = press_prev;
   end
`endif

   // Operand switches pass through their own 2-FF synchronizers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_a_s0 <= '0;
         sw_a_s1 <= '0;
         sw_b_s0 <= '0;
         sw_b_s1 <= '0;
      end else begin
         sw_a_s0 <= sw_a;
         sw_a_s1 <= sw_a_s0;
         sw_b_s0 <= sw_b;
         sw_b_s1 <= sw_b_s0;
      end
   end

   // Registered outputs: opposing step requests cancel; load is independent.
   always_ff @(posedge clk) begin
      if (rst) begin
         control    <= OP_ADD;
         a          <= '0;
         b          <= '0;
         op_changed <= 1'b0;
         loaded     <= 1'b0;
      end else begin
         op_changed <= 1'b0;
         if (step_up ^ step_dn) begin
            control    <= op_step(control, step_up, LAST_OP);
            op_changed <= 1'b1;
         end
         loaded <= press_load;
         if (press_load) begin
            a <= sw_a_s1;
            b <= sw_b_s1;
         end
      end
   end

endmodule
